// File: rtl/lcd_capture.sv
// Display-interface sink: tracks x/y from PPU strobes, packs four 2-bit pixels per
// byte and writes them through a small FIFO. Define LCD_CAPTURE_PALETTE_EN to store BGP shades.
module lcd_capture #(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 144,
  parameter int FIFO_DEPTH = 8,
  parameter int FB_AW      = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lcd_en,
  input  logic             lcd_pixel,
  input  logic [1:0]       lcd_color,
  input  logic             lcd_hsync,
  input  logic             lcd_vsync,
  input  logic [7:0]       bgp,
  output logic             fb_we,
  output logic [FB_AW-1:0] fb_addr,
  output logic [7:0]       fb_data,
  input  logic             fb_ready,
  output logic             frame_done,
  input  logic             err_clr,
  output logic             err_line,
  output logic             err_frame,
  output logic             err_ovf
);

  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [XW-1:0]    WIDTH_X    = XW'(WIDTH);
  localparam logic [YW-1:0]    HEIGHT_Y   = YW'(HEIGHT);
  localparam logic [FB_AW-1:0] LINE_BYTES = FB_AW'(WIDTH / 4);
  localparam logic [PW:0]      DEPTH_C    = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_SYNC, S_ACTIVE, S_FLUSH} state_t;

  state_t           state_q, state_d;
  logic             hsync_q, vsync_q, en_q;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [FB_AW-1:0] line_base_q, line_base_d;
  logic [FB_AW-1:0] addr_ctr_q, addr_ctr_d;
  logic [7:0]       pack_q, pack_d;
  logic             frame_done_q, frame_done_d;
  logic             err_line_q, err_line_d, err_frame_q, err_frame_d, err_ovf_q, err_ovf_d;
  logic             err_line_set, err_frame_set;
  logic             push, push_ok, pop, full;
  logic [FB_AW+7:0] push_data, head;
  logic [FB_AW+7:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic [1:0]       shade;

  wire hs_rise = lcd_hsync & ~hsync_q;
  wire vs_rise = lcd_vsync & ~vsync_q;
  wire vs_fall = ~lcd_vsync & vsync_q;
  wire en_rise = lcd_en & ~en_q;
  wire en_fall = ~lcd_en & en_q;

`ifdef LCD_CAPTURE_PALETTE_EN
  always_comb begin
    shade = 2'd0;
    case (lcd_color)
      2'd0: shade = bgp[1:0];
      2'd1: shade = bgp[3:2];
      2'd2: shade = bgp[5:4];
      2'd3: shade = bgp[7:6];
      default: shade = 2'd0;
    endcase
  end
`else
  logic unused_bgp;
  assign unused_bgp = ^bgp;
  assign shade = lcd_color;
`endif

  // Within one cycle: pixel first, then line end, then frame end; en fall overrides all.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    line_base_d   = line_base_q;
    addr_ctr_d    = addr_ctr_q;
    pack_d        = pack_q;
    frame_done_d  = 1'b0;
    err_line_set  = 1'b0;
    err_frame_set = 1'b0;
    push          = 1'b0;
    push_data     = {addr_ctr_q, pack_q};
    if (en_fall) begin
      state_d = S_SYNC;
      x_d     = '0;
      pack_d  = '0;
    end else begin
      case (state_q)
        S_SYNC: begin
          if (vs_fall || en_rise) begin
            x_d         = '0;
            y_d         = '0;
            line_base_d = '0;
            addr_ctr_d  = '0;
            pack_d      = '0;
            state_d     = S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (lcd_pixel && (y_q < HEIGHT_Y)) begin
            if (x_q < WIDTH_X) begin
              case (x_q[1:0])
                2'd0: pack_d[7:6] = shade;
                2'd1: pack_d[5:4] = shade;
                2'd2: pack_d[3:2] = shade;
                2'd3: pack_d[1:0] = shade;
                default: pack_d = pack_q;
              endcase
              x_d = x_q + XW'(1);
              if (x_q[1:0] == 2'd3) begin
                push       = 1'b1;
                push_data  = {addr_ctr_q, pack_d};
                addr_ctr_d = addr_ctr_q + FB_AW'(1);
              end
            end else begin
              err_line_set = 1'b1;
            end
          end
          if (hs_rise) begin
            if ((y_q < HEIGHT_Y) && (x_d != WIDTH_X)) err_line_set = 1'b1;
            line_base_d = line_base_q + LINE_BYTES;
            addr_ctr_d  = line_base_d;
            x_d         = '0;
            pack_d      = '0;
            if (y_q != '1) y_d = y_q + YW'(1);
          end
          if (vs_rise) begin
            if (y_d != HEIGHT_Y) err_frame_set = 1'b1;
            state_d = S_FLUSH;
          end
        end
        S_FLUSH: begin
          // Only ACTIVE pushes, so an empty FIFO here means every byte is written.
          if (count_q == '0) begin
            frame_done_d = 1'b1;
            state_d      = S_SYNC;
          end
        end
        default: state_d = S_SYNC;
      endcase
    end
  end

  // FIFO: valid/ready write port; a transfer happens on a cycle with fb_we=1 and fb_ready=1,
  // and the head is held unchanged until then.
  assign full    = (count_q == DEPTH_C);
  assign pop     = fb_we & fb_ready;
  assign push_ok = push & (~full | pop);

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (PW + 1)'(1);
      2'b01:   count_d = count_q - (PW + 1)'(1);
      default: count_d = count_q;
    endcase
    err_line_d  = (err_line_q & ~err_clr) | err_line_set;
    err_frame_d = (err_frame_q & ~err_clr) | err_frame_set;
    err_ovf_d   = (err_ovf_q & ~err_clr) | (push & full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (rst && push_ok) mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_SYNC;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      en_q         <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      line_base_q  <= '0;
      addr_ctr_q   <= '0;
      pack_q       <= '0;
      frame_done_q <= 1'b0;
      err_line_q   <= 1'b0;
      err_frame_q  <= 1'b0;
      err_ovf_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      hsync_q      <= lcd_hsync;
      vsync_q      <= lcd_vsync;
      en_q         <= lcd_en;
      x_q          <= x_d;
      y_q          <= y_d;
      line_base_q  <= line_base_d;
      addr_ctr_q   <= addr_ctr_d;
      pack_q       <= pack_d;
      frame_done_q <= frame_done_d;
      err_line_q   <= err_line_d;
      err_frame_q  <= err_frame_d;
      err_ovf_q    <= err_ovf_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  assign head       = mem[rd_ptr_q];
  assign fb_we      = (count_q != '0);
  assign fb_addr    = fb_we ? head[FB_AW+7:8] : '0;
  assign fb_data    = fb_we ? head[7:0] : '0;
  assign frame_done = frame_done_q;
  assign err_line   = err_line_q;
  assign err_frame  = err_frame_q;
  assign err_ovf    = err_ovf_q;

endmodule

// File: tb/tb_lcd_capture.sv
// Directed bench for lcd_capture: full frames, palette, FIFO stall/overflow,
// short line, lcd_en drop and short frame, each with hand-computed expectations.
module tb_lcd_capture;
  localparam int FB_AW = 13;

  logic             clk, rst, lcd_en, lcd_pixel, lcd_hsync, lcd_vsync;
  logic [1:0]       lcd_color;
  logic [7:0]       bgp;
  logic             fb_we, fb_ready, frame_done, err_clr, err_line, err_frame, err_ovf;
  logic [FB_AW-1:0] fb_addr;
  logic [7:0]       fb_data;

  lcd_capture dut (
    .clk(clk), .rst(rst), .lcd_en(lcd_en), .lcd_pixel(lcd_pixel), .lcd_color(lcd_color),
    .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .bgp(bgp), .fb_we(fb_we),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready), .frame_done(frame_done),
    .err_clr(err_clr), .err_line(err_line), .err_frame(err_frame), .err_ovf(err_ovf)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int miss_cnt = 0;
  int fd_cnt = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  int fd_cyc = 0;
  logic [FB_AW+7:0] got_q[$];
  logic [FB_AW+7:0] exp_q[$];

  // Write/frame monitor: samples late in the low phase, after inputs settle.
  always begin
    @(negedge clk);
    #2;
    cyc++;
    if (rst && fb_we && fb_ready) begin
      got_q.push_back({fb_addr, fb_data});
      last_wr_cyc = cyc;
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  // Driver tasks: inputs change just after the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_pixels(input int n, input int x0, input int fixed_c);
    for (int i = 0; i < n; i++) begin
      lcd_pixel = 1'b1;
      if (fixed_c >= 0) lcd_color = 2'(fixed_c);
      else lcd_color = 2'((x0 + i) % 4);
      tick();
    end
    lcd_pixel = 1'b0;
    lcd_color = 2'd0;
  endtask

  task automatic end_line();
    lcd_hsync = 1'b1;
    tick();
    tick();
    lcd_hsync = 1'b0;
    tick();
  endtask

  task automatic drive_lines(input int n);
    for (int l = 0; l < n; l++) begin
      drive_pixels(160, 0, -1);
      end_line();
    end
  endtask

  task automatic begin_frame();
    lcd_vsync = 1'b0;
    tick();
  endtask

  task automatic end_frame(output bit seen);
    int start;
    start = fd_cnt;
    seen = 1'b0;
    lcd_vsync = 1'b1;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      if (fd_cnt != start) seen = 1'b1;
    end
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    lcd_en = 1'b0; lcd_pixel = 1'b0; lcd_color = 2'd0; lcd_hsync = 1'b0;
    lcd_vsync = 1'b1; bgp = 8'hE4; fb_ready = 1'b1; err_clr = 1'b0;
    repeat (5) tick();
    vec_cnt++;
    if ({fb_we, fb_addr, fb_data} !== '0) begin
      miss_cnt++;
      $display("FAIL reset_fb_port: got we=%b addr=%0d data=%h want 0/0/00", fb_we, fb_addr, fb_data);
    end
    vec_cnt++;
    if ({frame_done, err_line, err_frame, err_ovf} !== 4'b0) begin
      miss_cnt++;
      $display("FAIL reset_flags: got %b want 0000", {frame_done, err_line, err_frame, err_ovf});
    end
    rst = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_full_frame();
    bit seen;
    int bad, start_fd;
    got_q.delete();
    exp_q.delete();
    for (int a = 0; a < 5760; a++) exp_q.push_back({13'(a), 8'h1B});
    start_fd = fd_cnt;
    lcd_en = 1'b1;
    tick();
    begin_frame();
    drive_lines(144);
    end_frame(seen);
    repeat (5) tick();
    vec_cnt++;
    if (seen !== 1'b1) begin miss_cnt++; $display("FAIL full_frame_done: got none want pulse"); end
    vec_cnt++;
    if (fd_cnt - start_fd != 1) begin
      miss_cnt++; $display("FAIL full_frame_done_count: got %0d want 1", fd_cnt - start_fd);
    end
    vec_cnt++;
    if (fd_cyc <= last_wr_cyc) begin
      miss_cnt++; $display("FAIL full_done_order: got done@%0d last_wr@%0d want done later", fd_cyc, last_wr_cyc);
    end
    vec_cnt++;
    if (got_q.size() != exp_q.size()) begin
      miss_cnt++; $display("FAIL full_write_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    bad = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
    vec_cnt++;
    if (bad != 0) begin miss_cnt++; $display("FAIL full_write_data: got %0d bad entries want 0", bad); end
    vec_cnt++;
    if ({err_line, err_frame, err_ovf} !== 3'b000) begin
      miss_cnt++; $display("FAIL full_errors: got %b want 000", {err_line, err_frame, err_ovf});
    end
  endtask

  task automatic test_palette();
    bit seen;
    logic [7:0] second;
`ifdef LCD_CAPTURE_PALETTE_EN
    second = 8'hAA;
`else
    second = 8'h55;
`endif
    got_q.delete();
    exp_q.delete();
    exp_q.push_back({13'd0, 8'h55});
    exp_q.push_back({13'd1, 8'h55});
    exp_q.push_back({13'd40, second});
    exp_q.push_back({13'd41, second});
    bgp = 8'hE4;
    begin_frame();
    drive_pixels(8, 0, 1);
    end_line();
    bgp = 8'h1B;
    drive_pixels(8, 0, 1);
    end_line();
    end_frame(seen);
    bgp = 8'hE4;
    vec_cnt++;
    if (got_q.size() != 4) begin miss_cnt++; $display("FAIL palette_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      vec_cnt++;
      if (got_q[i] !== exp_q[i]) begin
        miss_cnt++; $display("FAIL palette_byte%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    vec_cnt++;
    if (err_line !== 1'b1) begin miss_cnt++; $display("FAIL palette_err_line: got %b want 1", err_line); end
    pulse_err_clr();
  endtask

  task automatic test_overflow();
    bit seen;
    int unstable, bad;
    got_q.delete();
    exp_q.delete();
    for (int a = 0; a < 40; a++) if (a != 13 && a != 14) exp_q.push_back({13'(a), 8'h1B});
    begin_frame();
    drive_pixels(20, 0, -1);
    tick();
    tick();
    fb_ready = 1'b0;
    unstable = 0;
    for (int i = 0; i < 40; i++) begin
      lcd_pixel = 1'b1;
      lcd_color = 2'((20 + i) % 4);
      tick();
      if (i >= 3 && !(fb_we === 1'b1 && fb_addr === 13'd5 && fb_data === 8'h1B)) unstable++;
      if (i == 31) begin
        vec_cnt++;
        if (err_ovf !== 1'b0) begin miss_cnt++; $display("FAIL ovf_at_8: got %b want 0", err_ovf); end
      end
      if (i == 35) begin
        vec_cnt++;
        if (err_ovf !== 1'b1) begin miss_cnt++; $display("FAIL ovf_at_9: got %b want 1", err_ovf); end
      end
    end
    vec_cnt++;
    if (unstable != 0) begin miss_cnt++; $display("FAIL ovf_stall_stable: got %0d unstable cycles want 0", unstable); end
    fb_ready = 1'b1;
    drive_pixels(100, 60, -1);
    end_line();
    end_frame(seen);
    vec_cnt++;
    if (seen !== 1'b1) begin miss_cnt++; $display("FAIL ovf_frame_done: got none want pulse"); end
    vec_cnt++;
    if (got_q.size() != exp_q.size()) begin
      miss_cnt++; $display("FAIL ovf_write_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    bad = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
    vec_cnt++;
    if (bad != 0) begin miss_cnt++; $display("FAIL ovf_write_data: got %0d bad entries want 0", bad); end
    pulse_err_clr();
    vec_cnt++;
    if ({err_line, err_frame, err_ovf} !== 3'b000) begin
      miss_cnt++; $display("FAIL ovf_err_clr: got %b want 000", {err_line, err_frame, err_ovf});
    end
  endtask

  task automatic test_short_line();
    bit seen;
    int bad, hit159;
    got_q.delete();
    exp_q.delete();
    for (int a = 0; a < 159; a++) exp_q.push_back({13'(a), 8'h1B});
    for (int a = 160; a < 200; a++) exp_q.push_back({13'(a), 8'h1B});
    begin_frame();
    drive_lines(3);
    vec_cnt++;
    if (err_line !== 1'b0) begin miss_cnt++; $display("FAIL short_pre_err_line: got %b want 0", err_line); end
    drive_pixels(157, 0, -1);
    end_line();
    vec_cnt++;
    if (err_line !== 1'b1) begin miss_cnt++; $display("FAIL short_err_line: got %b want 1", err_line); end
    drive_lines(1);
    end_frame(seen);
    hit159 = 0;
    foreach (got_q[i]) if (got_q[i][FB_AW+7:8] == 13'd159) hit159++;
    vec_cnt++;
    if (hit159 != 0) begin miss_cnt++; $display("FAIL short_addr159: got %0d writes want 0", hit159); end
    vec_cnt++;
    if (got_q.size() != exp_q.size()) begin
      miss_cnt++; $display("FAIL short_write_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    bad = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
    vec_cnt++;
    if (bad != 0) begin miss_cnt++; $display("FAIL short_write_data: got %0d bad entries want 0", bad); end
    pulse_err_clr();
  endtask

  task automatic test_en_drop();
    bit seen;
    int bad, start_fd;
    got_q.delete();
    exp_q.delete();
    for (int a = 0; a < 2005; a++) exp_q.push_back({13'(a), 8'h1B});
    start_fd = fd_cnt;
    begin_frame();
    drive_lines(50);
    fb_ready = 1'b0;
    drive_pixels(20, 0, -1);
    lcd_en = 1'b0;
    tick();
    vec_cnt++;
    if (fb_we !== 1'b1) begin miss_cnt++; $display("FAIL endrop_fifo_held: got we=%b want 1", fb_we); end
    fb_ready = 1'b1;
    repeat (10) tick();
    vec_cnt++;
    if (fd_cnt != start_fd) begin miss_cnt++; $display("FAIL endrop_no_done: got %0d pulses want 0", fd_cnt - start_fd); end
    vec_cnt++;
    if (got_q.size() != exp_q.size()) begin
      miss_cnt++; $display("FAIL endrop_write_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    bad = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
    vec_cnt++;
    if (bad != 0) begin miss_cnt++; $display("FAIL endrop_write_data: got %0d bad entries want 0", bad); end
    lcd_en = 1'b1;
    tick();
    got_q.delete();
    drive_pixels(8, 0, -1);
    repeat (3) tick();
    vec_cnt++;
    if (got_q.size() != 2) begin
      miss_cnt++; $display("FAIL endrop_restart_count: got %0d want 2", got_q.size());
    end else begin
      vec_cnt++;
      if (got_q[0] !== {13'd0, 8'h1B}) begin
        miss_cnt++; $display("FAIL endrop_restart_addr: got %h want %h", got_q[0], {13'd0, 8'h1B});
      end
    end
    end_frame(seen);
    vec_cnt++;
    if (seen !== 1'b1) begin miss_cnt++; $display("FAIL endrop_second_done: got none want pulse"); end
    pulse_err_clr();
  endtask

  task automatic test_frame_count();
    bit seen;
    begin_frame();
    drive_lines(143);
    end_frame(seen);
    vec_cnt++;
    if ({err_frame, err_line} !== 2'b10) begin
      miss_cnt++; $display("FAIL frame143_errs: got frame/line=%b want 10", {err_frame, err_line});
    end
    pulse_err_clr();
    vec_cnt++;
    if (err_frame !== 1'b0) begin miss_cnt++; $display("FAIL frame143_clr: got %b want 0", err_frame); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_palette();
    test_overflow();
    test_short_line();
    test_en_drop();
    test_frame_count();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
